// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module   : fetch_ctrl_pkg
// Purpose  : Shared definitions for the instruction fetch controller:
//            default widths, FSM state encodings and the next-PC select type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

  // Default widths used by fetch_ctrl and pc_next_sel.
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_INSTR_W = 32;

  // FSM state encodings (2-bit).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // Next-PC source selection.
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage : fetch_ctrl_pkg

`default_nettype wire

// File: rtl/fetch_ctrl_pc_next_sel.sv
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Combinational next-PC multiplexer (hold / increment / redirect)
//            and comparison of the delivered instruction address against the
//            halt address.
// Ports    : pc            - current program counter
//            sel           - next-PC source
//            redirect_addr - branch/jump target
//            instr_pc      - address of the word currently held for decode
//            pc_next       - selected next program counter
//            at_halt       - instr_pc equals HALT_ADDR
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(13)
) (
  input  logic [ADDR_W-1:0] pc,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              at_halt
);

  // Increment wraps naturally modulo 2^ADDR_W.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_HOLD:     pc_next = pc;
      PC_INC:      pc_next = pc + ADDR_W'(1);
      PC_REDIRECT: pc_next = redirect_addr;
      default:     pc_next = pc;
    endcase
  end

  assign at_halt = (instr_pc == HALT_ADDR);

endmodule : pc_next_sel

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction fetch sequencer. Owns the program counter, keeps at
//            most one instruction-memory request outstanding, and hands each
//            fetched word to decode over a valid/ready handshake. Honours
//            pipeline stall, branch redirect and a halt address.
// Ports    : clk, rst                  - clock, async active-high reset
//            stall_en                  - blocks handoff to decode
//            redirect_valid/_addr      - one-cycle PC redirect
//            imem_req/_addr            - fetch request, held until imem_ack
//            imem_ack/_rdata           - memory response
//            instr_valid/_out/_pc      - word presented to decode
//            instr_ready               - decode ready
//            halted                    - high while in the HALT state
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                INSTR_W   = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(13)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic               halted
);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              flush_next;
  logic              handoff;
  logic              accept;
  logic              new_req;
  logic              at_halt;
  pc_sel_e           pc_sel;

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  pc_next_sel #(
    .ADDR_W    (ADDR_W),
    .HALT_ADDR (HALT_ADDR)
  ) u_pc_next_sel (
    .pc            (pc),
    .sel           (pc_sel),
    .redirect_addr (redirect_addr),
    .instr_pc      (instr_pc),
    .pc_next       (pc_next),
    .at_halt       (at_halt)
  );

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  always_comb begin
    // instr_valid is high exactly in HOLD, so HOLD stands in for it here.
    handoff = (state == ST_HOLD) && instr_ready && !stall_en;

    // A response is kept only if no redirect has overtaken it (earlier flush
    // or a redirect in the very same cycle).
    accept  = (state == ST_REQ) && imem_ack && !flush && !redirect_valid;

    // Redirect always wins; the PC only advances on a kept response.
    pc_sel = PC_HOLD;
    if (redirect_valid) begin
      pc_sel = PC_REDIRECT;
    end else if (accept) begin
      pc_sel = PC_INC;
    end

    state_next = state;
    case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (accept) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_next = ST_REQ;
        end else if (handoff) begin
          state_next = at_halt ? ST_HALT : ST_REQ;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // flush marks an in-flight request whose data must be thrown away.
    // It only lives in REQ and is retired by the ack it was waiting for.
    flush_next = 1'b0;
    if (state == ST_REQ) begin
      if (imem_ack) begin
        flush_next = 1'b0;
      end else if (redirect_valid) begin
        flush_next = 1'b1;
      end else begin
        flush_next = flush;
      end
    end

    // A fresh address is launched whenever REQ is (re)entered, or when the
    // current request completes and REQ is kept. A request still waiting
    // for its ack keeps its address even if the PC is redirected.
    new_req = (state_next == ST_REQ) && !((state == ST_REQ) && !imem_ack);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      flush       <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      flush       <= flush_next;
      instr_valid <= (state_next == ST_HOLD);
      halted      <= (state_next == ST_HALT);
      if (new_req) begin
        req_addr <= pc_next;
      end
      if (accept) begin
        instr_out <= imem_rdata;
        instr_pc  <= pc;
      end
    end
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = req_addr;

endmodule : fetch_ctrl

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl. A behavioural memory answers
//            requests after a programmable delay; expected instruction
//            addresses are queued by the directed sequence and compared at
//            every decode handoff.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               rst;
  logic               stall_en;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               halted;

  int n_checks = 0;
  int n_fails  = 0;

  logic [ADDR_W-1:0] exp_q[$];

  logic               mem_auto;
  int                 ack_delay;
  logic               man_ack;
  logic [INSTR_W-1:0] man_rdata;

  fetch_ctrl #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .RESET_PC  (9'd0),
    .HALT_ADDR (9'd13)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_en       (stall_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, 7'h00, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(ADDR_W'(a));
  endtask

  task automatic pulse_redirect(input logic [ADDR_W-1:0] a);
    redirect_addr  = a;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_halted(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("halt_reached", 32'(halted), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Memory model: acks ack_delay cycles after it first sees a request, and
  // checks that the request and its address stay put while waiting.
  initial begin : mem_model
    int                cnt;
    logic [ADDR_W-1:0] held;
    cnt        = 0;
    held       = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_auto) begin
        cnt        = 0;
        imem_ack   = man_ack;
        imem_rdata = man_rdata;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        cnt      = 0;
      end else if (imem_req) begin
        if (cnt == 0) held = imem_addr;
        else check("req_addr_stable", 32'(imem_addr), 32'(held));
        cnt++;
        if (cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = word_of(imem_addr);
        end
      end else begin
        if (cnt != 0) check("req_held_until_ack", 32'(imem_req), 32'd1);
        cnt = 0;
      end
    end
  end

  // Handoff monitor: every accepted word must be the next expected one.
  initial begin : handoff_mon
    logic [ADDR_W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instr_valid && instr_ready && !stall_en) begin
        if (exp_q.size() == 0) begin
          check("handoff_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(e));
          check("instr_out", instr_out, word_of(e));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst            = 1'b1;
    stall_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    instr_ready    = 1'b1;
    mem_auto       = 1'b1;
    ack_delay      = 1;
    man_ack        = 1'b0;
    man_rdata      = '0;

    // Reset state
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Straight-line fetch 0..13 with a fast memory, then halt
    push_range(0, 13);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_req_addr", 32'(imem_addr), 32'd0);
    wait_halted(200);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_no_req", 32'(imem_req), 32'd0);
    end

    // Redirect out of HALT to 2 with a 4-cycle memory
    ack_delay = 4;
    push_range(2, 13);
    pulse_redirect(9'd2);
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_req", 32'(imem_req), 32'd1);
    check("unhalt_addr", 32'(imem_addr), 32'd2);
    wait_halted(400);

    // Stall while a word is held for decode
    ack_delay = 1;
    stall_en  = 1'b1;
    push_range(10, 13);
    pulse_redirect(9'd10);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", 32'(instr_pc), 32'd10);
      check("stall_out", instr_out, word_of(9'd10));
      check("stall_no_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    stall_en = 1'b0;
    @(negedge clk);
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", 32'(imem_addr), 32'd11);
    check("resume_valid", 32'(instr_valid), 32'd0);
    wait_halted(200);

    // Redirect to 7 while the request for 3 is outstanding
    ack_delay = 4;
    push_range(7, 13);
    pulse_redirect(9'd3);
    check("req3_addr", 32'(imem_addr), 32'd3);
    pulse_redirect(9'd7);
    check("flush_req_kept", 32'(imem_req), 32'd1);
    check("flush_addr_kept", 32'(imem_addr), 32'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_addr != 9'd3) break;
    end
    check("redirect_req", 32'(imem_req), 32'd1);
    check("redirect_addr", 32'(imem_addr), 32'd7);
    wait_halted(400);

    // Reset in the middle of a request, then a late ack
    mem_auto = 1'b0;
    pulse_redirect(9'd5);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    check("pre_rst_addr", 32'(imem_addr), 32'd5);
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_out", instr_out, 32'd0);
    check("midrst_pc", 32'(instr_pc), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", 32'(imem_addr), 32'd0);
    man_ack = 1'b0;
    push_range(0, 13);
    mem_auto = 1'b1;
    wait_halted(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_fetch_ctrl

`default_nettype wire
